// File: rtl/spart_driver.sv
// Bus master standing in for the processor on the SPART port: programs the
// baud divisor from the board switches, then echoes every received byte.
module spart_driver #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [2:0] dbg_state
);

  localparam logic [15:0] DIV_4800  = 16'(CLK_HZ / (16 * 4800) - 1);
  localparam logic [15:0] DIV_9600  = 16'(CLK_HZ / (16 * 9600) - 1);
  localparam logic [15:0] DIV_19200 = 16'(CLK_HZ / (16 * 19200) - 1);
  localparam logic [15:0] DIV_38400 = 16'(CLK_HZ / (16 * 38400) - 1);

  typedef enum logic [2:0] {
    S_INIT_LO  = 3'd0,
    S_INIT_HI  = 3'd1,
    S_POLL_RX  = 3'd2,
    S_READ_RX  = 3'd3,
    S_POLL_TX  = 3'd4,
    S_WRITE_TX = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_sync1;
  logic [1:0]  r_sync2;
  logic [1:0]  r_cfg_q;
  logic [7:0]  r_hold;
  logic [7:0]  w_dout;
  logic [15:0] w_div;

  // Bus handshake: iocs is a single-cycle strobe; iorw=0 means the driver
  // owns databus for that cycle, iorw=1 means the SPART drives it.
  assign databus   = (iocs && !iorw) ? w_dout : 8'hzz;
  assign dbg_state = r_state;

  always_comb begin
    w_div = DIV_4800;
    case (r_cfg_q)
      2'b01:   w_div = DIV_9600;
      2'b10:   w_div = DIV_19200;
      2'b11:   w_div = DIV_38400;
      default: w_div = DIV_4800;
    endcase
  end

  always_comb begin
    w_next = r_state;
    iocs   = 1'b0;
    iorw   = 1'b1;
    ioaddr = 2'b00;
    w_dout = 8'h00;
    // Reset holds the bus idle even though the state already sits in INIT_LO.
    if (!rst) begin
      case (r_state)
        S_INIT_LO: begin
          iocs   = 1'b1;
          iorw   = 1'b0;
          ioaddr = 2'b10;
          w_dout = w_div[7:0];
          w_next = S_INIT_HI;
        end
        S_INIT_HI: begin
          iocs   = 1'b1;
          iorw   = 1'b0;
          ioaddr = 2'b11;
          w_dout = w_div[15:8];
          w_next = S_POLL_RX;
        end
        S_POLL_RX: begin
          if (r_sync2 != r_cfg_q) begin
            w_next = S_INIT_LO;
          end else if (rda) begin
            w_next = S_READ_RX;
          end
        end
        S_READ_RX: begin
          iocs   = 1'b1;
          iorw   = 1'b1;
          w_next = S_POLL_TX;
        end
        S_POLL_TX: begin
          if (tbr) begin
            w_next = S_WRITE_TX;
          end
        end
        S_WRITE_TX: begin
          iocs   = 1'b1;
          iorw   = 1'b0;
          w_dout = r_hold;
          w_next = S_POLL_RX;
        end
        default: w_next = S_INIT_LO;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // The synchronizer keeps sampling through reset so the init sequence
    // that follows reset already programs the current switch setting.
    r_sync1 <= br_cfg;
    r_sync2 <= r_sync1;
    if (rst) begin
      r_state <= S_INIT_LO;
      r_hold  <= 8'h00;
      r_cfg_q <= r_sync2;
    end else begin
      r_state <= w_next;
      if (w_next == S_INIT_LO) begin
        r_cfg_q <= r_sync2;
      end
      if (r_state == S_READ_RX) begin
        r_hold <= databus;
      end
    end
  end

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: a small SPART model serves bytes, a monitor checks
// every bus cycle against divisor arithmetic and an echo queue.
module tb_spart_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic       rda;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [2:0] dbg_state;
  logic [7:0] spart_dout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] rx_q[$];
  logic [7:0] echo_q[$];
  int reads_seen    = 0;
  int pops_done     = 0;
  int write_cnt     = 0;
  int init_lo_cnt   = 0;
  int last_init_cyc = -1;
  int last_read_cyc = -1;
  int last_write_cyc = -1;
  logic prev_rda = 1'b0;
  logic prev_tbr = 1'b0;
  logic [1:0] exp_cfg;

  always #5 clk = ~clk;

  spart_driver #(.CLK_HZ(50_000_000)) dut (
    .clk       (clk),
    .rst       (rst),
    .br_cfg    (br_cfg),
    .rda       (rda),
    .tbr       (tbr),
    .iocs      (iocs),
    .iorw      (iorw),
    .ioaddr    (ioaddr),
    .databus   (databus),
    .dbg_state (dbg_state)
  );

  // SPART side of the shared bus: drives only during read strobes.
  assign databus = (iocs && iorw) ? spart_dout : 8'hzz;

  function automatic logic [15:0] exp_div(input logic [1:0] cfg);
    int baud;
    baud = 4800 << cfg;
    return 16'(50_000_000 / (16 * baud) - 1);
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [15:0] dv;
    cyc++;
    dv = exp_div(exp_cfg);
    if (rst) begin
      chk("rst_idle", int'({iocs, iorw, ioaddr}), 4);
      echo_q.delete();
    end
    if (iocs && !iorw) begin
      chk("wr_not_status", int'(ioaddr == 2'b01), 0);
      case (ioaddr)
        2'b10: begin
          chk("init_lo", int'(databus), int'(dv[7:0]));
          init_lo_cnt++;
          last_init_cyc = cyc;
        end
        2'b11: begin
          chk("init_hi", int'(databus), int'(dv[15:8]));
          chk("init_hi_gap", cyc - last_init_cyc, 1);
        end
        2'b00: begin
          chk("echo_pending", echo_q.size(), 1);
          if (echo_q.size() != 0) begin
            chk("echo_data", int'(databus), int'(echo_q.pop_front()));
          end
          chk("wr_tbr", int'(prev_tbr), 1);
          write_cnt++;
          last_write_cyc = cyc;
        end
        default: ;
      endcase
    end else if (iocs && iorw) begin
      chk("rd_addr", int'(ioaddr), 0);
      chk("rd_rda", int'(prev_rda), 1);
      chk("rd_bus", int'(databus), int'(spart_dout));
      echo_q.push_back(databus);
      reads_seen++;
      last_read_cyc = cyc;
    end else begin
      chk("bus_z", int'(databus === 8'hzz), 1);
    end
    prev_rda = rda;
    prev_tbr = tbr;
  end

  // Advance one cycle; the SPART model retires bytes consumed by reads.
  task automatic tick();
    @(posedge clk);
    #2;
    while (pops_done < reads_seen) begin
      if (rx_q.size() != 0) void'(rx_q.pop_front());
      pops_done++;
    end
    rda        = (rx_q.size() != 0);
    spart_dout = (rx_q.size() != 0) ? rx_q[0] : 8'hEE;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_q.push_back(b);
    rda        = 1'b1;
    spart_dout = rx_q[0];
  endtask

  initial begin
    int k, m, rel, w0, i0, pushed;
    rst = 1'b1; br_cfg = 2'b01; exp_cfg = 2'b01;
    rda = 1'b0; tbr = 1'b0; spart_dout = 8'hEE;
    repeat (4) tick();

    // Init after reset with 9600 baud selected
    rst = 1'b0;
    rel = cyc + 1;
    repeat (6) tick();
    chk("t1_init_cnt", init_lo_cnt, 1);
    chk("t1_init_cyc", last_init_cyc, rel);
    chk("t1_no_xfer", write_cnt + reads_seen, 0);

    // Echo with transmitter ready
    tbr = 1'b1;
    tick();
    k = cyc;
    push_byte(8'h5A);
    repeat (6) tick();
    chk("t2_rd_cyc", last_read_cyc, k + 2);
    chk("t2_wr_cyc", last_write_cyc, k + 4);
    chk("t2_wr_cnt", write_cnt, 1);

    // Transmitter busy for 20+ cycles
    tbr = 1'b0;
    tick();
    k = cyc;
    w0 = write_cnt;
    push_byte(8'hA5);
    repeat (22) tick();
    chk("t3_rd_cyc", last_read_cyc, k + 2);
    chk("t3_no_wr", write_cnt, w0);
    m = cyc;
    tbr = 1'b1;
    repeat (4) tick();
    chk("t3_wr_cyc", last_write_cyc, m + 2);
    chk("t3_wr_cnt", write_cnt, w0 + 1);

    // Baud change races a pending byte; re-init must win
    repeat (3) tick();
    m = cyc;
    br_cfg = 2'b11;
    exp_cfg = 2'b11;
    tick();
    tick();
    push_byte(8'h77);
    repeat (10) tick();
    chk("t4_init_cyc", last_init_cyc, m + 4);
    chk("t4_rd_cyc", last_read_cyc, m + 7);
    chk("t4_wr_cyc", last_write_cyc, m + 9);

    // Reset while a byte waits for the transmitter
    tbr = 1'b0;
    tick();
    push_byte(8'h3C);
    repeat (5) tick();
    w0 = write_cnt;
    i0 = init_lo_cnt;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    rel = cyc + 1;
    tbr = 1'b1;
    repeat (10) tick();
    chk("t5_init_cyc", last_init_cyc, rel);
    chk("t5_init_cnt", init_lo_cnt, i0 + 1);
    chk("t5_no_wr", write_cnt, w0);

    // Random traffic with a flaky transmitter
    pushed = 0;
    w0 = write_cnt;
    for (int i = 0; i < 400; i++) begin
      tick();
      tbr = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0 && rx_q.size() < 3) begin
        push_byte(8'($urandom_range(0, 255)));
        pushed++;
      end
    end
    tbr = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (rx_q.size() == 0 && echo_q.size() == 0 && pops_done == reads_seen) break;
      tick();
    end
    repeat (2) tick();
    chk("rand_drain", rx_q.size() + echo_q.size(), 0);
    chk("rand_count", write_cnt - w0, pushed);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
